// File: rtl/mem_access_stage.sv
// Memory-access stage: aligns load/store traffic onto a 32-bit word-wide data
// memory port and returns one registered write-back result per instruction.
//
// state  | meaning
// IDLE   | ready for a new instruction; non-memory ops and faults retire here
// REQ    | memory request presented, waiting for dmem_req_ready_i
// RESP   | load request accepted, waiting for dmem_rsp_valid_i
module mem_access_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [31:0] ex_alu_result_i,
    input  logic [31:0] ex_store_data_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic        ex_is_load_i,
    input  logic        ex_is_store_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_reg_write_i,
    output logic        dmem_req_valid_o,
    input  logic        dmem_req_ready_i,
    output logic [31:0] dmem_addr_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_wstrb_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_rsp_valid_i,
    input  logic [31:0] dmem_rsp_rdata_i,
    output logic        wb_valid_o,
    output logic [31:0] wb_result_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_reg_write_o,
    output logic        wb_fault_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d;

    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_result_q, wb_result_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_rw_q, wb_rw_d;
    logic        wb_fault_q, wb_fault_d;

    logic        acc_fault;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    // Legality of the incoming load/store: type conflict, funct3, alignment.
    always_comb begin
        acc_fault = 1'b0;
        if (ex_is_load_i && ex_is_store_i) begin
            acc_fault = 1'b1;
        end else if (ex_is_load_i) begin
            case (ex_funct3_i)
                3'b000, 3'b100: acc_fault = 1'b0;
                3'b001, 3'b101: acc_fault = ex_alu_result_i[0];
                3'b010:         acc_fault = |ex_alu_result_i[1:0];
                default:        acc_fault = 1'b1;
            endcase
        end else if (ex_is_store_i) begin
            case (ex_funct3_i)
                3'b000:  acc_fault = 1'b0;
                3'b001:  acc_fault = ex_alu_result_i[0];
                3'b010:  acc_fault = |ex_alu_result_i[1:0];
                default: acc_fault = 1'b1;
            endcase
        end
    end

    // Store data is replicated across lanes; the strobe selects the target bytes.
    always_comb begin
        st_wdata = ex_store_data_i;
        st_wstrb = 4'b1111;
        case (ex_funct3_i[1:0])
            2'b00: begin
                st_wdata = {4{ex_store_data_i[7:0]}};
                st_wstrb = 4'b0001 << ex_alu_result_i[1:0];
            end
            2'b01: begin
                st_wdata = {2{ex_store_data_i[15:0]}};
                st_wstrb = 4'b0011 << ex_alu_result_i[1:0];
            end
            default: begin
                st_wdata = ex_store_data_i;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Pick the addressed byte/halfword out of the returned word and extend it.
    always_comb begin
        ld_half = addr_q[1] ? dmem_rsp_rdata_i[31:16] : dmem_rsp_rdata_i[15:0];
        case (addr_q[1:0])
            2'b00:   ld_byte = dmem_rsp_rdata_i[7:0];
            2'b01:   ld_byte = dmem_rsp_rdata_i[15:8];
            2'b10:   ld_byte = dmem_rsp_rdata_i[23:16];
            default: ld_byte = dmem_rsp_rdata_i[31:24];
        endcase
        case (funct3_q)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_value = {24'd0, ld_byte};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_value = {16'd0, ld_half};
            default: ld_value = dmem_rsp_rdata_i;
        endcase
    end

    // Next-state and write-back logic; wb fields other than valid hold by default.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        rw_d        = rw_q;
        wb_valid_d  = 1'b0;
        wb_result_d = wb_result_q;
        wb_rd_d     = wb_rd_q;
        wb_rw_d     = wb_rw_q;
        wb_fault_d  = wb_fault_q;

        case (state_q)
            S_IDLE: begin
                if (ex_valid_i) begin
                    if (acc_fault) begin
                        wb_valid_d  = 1'b1;
                        wb_result_d = ex_alu_result_i;
                        wb_rd_d     = ex_rd_i;
                        wb_rw_d     = 1'b0;
                        wb_fault_d  = 1'b1;
                    end else if (ex_is_load_i || ex_is_store_i) begin
                        addr_d   = ex_alu_result_i;
                        we_d     = ex_is_store_i;
                        wstrb_d  = ex_is_store_i ? st_wstrb : 4'b0000;
                        wdata_d  = ex_is_store_i ? st_wdata : 32'd0;
                        funct3_d = ex_funct3_i;
                        rd_d     = ex_rd_i;
                        rw_d     = ex_reg_write_i;
                        state_d  = S_REQ;
                    end else begin
                        wb_valid_d  = 1'b1;
                        wb_result_d = ex_alu_result_i;
                        wb_rd_d     = ex_rd_i;
                        wb_rw_d     = ex_reg_write_i;
                        wb_fault_d  = 1'b0;
                    end
                end
            end
            S_REQ: begin
                if (dmem_req_ready_i) begin
                    if (we_q) begin
                        wb_valid_d  = 1'b1;
                        wb_result_d = 32'd0;
                        wb_rd_d     = rd_q;
                        wb_rw_d     = 1'b0;
                        wb_fault_d  = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (dmem_rsp_valid_i) begin
                    wb_valid_d  = 1'b1;
                    wb_result_d = ld_value;
                    wb_rd_d     = rd_q;
                    wb_rw_d     = rw_q;
                    wb_fault_d  = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any outstanding transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'd0;
            we_q        <= 1'b0;
            wstrb_q     <= 4'd0;
            wdata_q     <= 32'd0;
            funct3_q    <= 3'd0;
            rd_q        <= 5'd0;
            rw_q        <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_result_q <= 32'd0;
            wb_rd_q     <= 5'd0;
            wb_rw_q     <= 1'b0;
            wb_fault_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
            wb_valid_q  <= wb_valid_d;
            wb_result_q <= wb_result_d;
            wb_rd_q     <= wb_rd_d;
            wb_rw_q     <= wb_rw_d;
            wb_fault_q  <= wb_fault_d;
        end
    end

    assign ex_ready_o       = (state_q == S_IDLE);
    assign dmem_req_valid_o = (state_q == S_REQ);
    assign dmem_addr_o      = {addr_q[31:2], 2'b00};
    assign dmem_we_o        = we_q;
    assign dmem_wstrb_o     = wstrb_q;
    assign dmem_wdata_o     = wdata_q;
    assign wb_valid_o       = wb_valid_q;
    assign wb_result_o      = wb_result_q;
    assign wb_rd_o          = wb_rd_q;
    assign wb_reg_write_o   = wb_rw_q;
    assign wb_fault_o       = wb_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected write-back records are queued
// when an instruction is issued and matched when wb_valid_o pulses.
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [31:0] ex_alu_result_i;
    logic [31:0] ex_store_data_i;
    logic [2:0]  ex_funct3_i;
    logic        ex_is_load_i;
    logic        ex_is_store_i;
    logic [4:0]  ex_rd_i;
    logic        ex_reg_write_i;
    logic        dmem_req_valid_o;
    logic        dmem_req_ready_i;
    logic [31:0] dmem_addr_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_wstrb_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_rsp_valid_i;
    logic [31:0] dmem_rsp_rdata_i;
    logic        wb_valid_o;
    logic [31:0] wb_result_o;
    logic [4:0]  wb_rd_o;
    logic        wb_reg_write_o;
    logic        wb_fault_o;

    mem_access_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid_i       (ex_valid_i),
        .ex_ready_o       (ex_ready_o),
        .ex_alu_result_i  (ex_alu_result_i),
        .ex_store_data_i  (ex_store_data_i),
        .ex_funct3_i      (ex_funct3_i),
        .ex_is_load_i     (ex_is_load_i),
        .ex_is_store_i    (ex_is_store_i),
        .ex_rd_i          (ex_rd_i),
        .ex_reg_write_i   (ex_reg_write_i),
        .dmem_req_valid_o (dmem_req_valid_o),
        .dmem_req_ready_i (dmem_req_ready_i),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_we_o        (dmem_we_o),
        .dmem_wstrb_o     (dmem_wstrb_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_rsp_valid_i (dmem_rsp_valid_i),
        .dmem_rsp_rdata_i (dmem_rsp_rdata_i),
        .wb_valid_o       (wb_valid_o),
        .wb_result_o      (wb_result_o),
        .wb_rd_o          (wb_rd_o),
        .wb_reg_write_o   (wb_reg_write_o),
        .wb_fault_o       (wb_fault_o)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic        fault;
        logic        chk_rd;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int last_wb_cyc = 0;
    int wb_count = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic [31:0] res, input logic [4:0] rd, input logic rw,
                            input logic fault, input logic chk_rd);
        wb_exp_t e;
        e.res = res; e.rd = rd; e.rw = rw; e.fault = fault; e.chk_rd = chk_rd;
        exp_q.push_back(e);
    endtask

    // Drives one instruction for one accepting edge; leaves ex_valid_i asserted.
    task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [2:0] f3,
                         input logic ld, input logic st, input logic [4:0] rd, input logic rw);
        ex_valid_i      = 1'b1;
        ex_alu_result_i = alu;
        ex_store_data_i = sd;
        ex_funct3_i     = f3;
        ex_is_load_i    = ld;
        ex_is_store_i   = st;
        ex_rd_i         = rd;
        ex_reg_write_i  = rw;
        check_eq("ex_ready_at_issue", ex_ready_o, 1);
        @(posedge clk); #1;
        acc_cyc = cyc - 1;
    endtask

    // Memory side of one transaction, entered in the cycle after accept.
    task automatic mem_txn(input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                           input logic [31:0] e_addr, input logic e_we,
                           input logic [3:0] e_wstrb, input logic [31:0] e_wdata);
        int n;
        n = 0;
        @(negedge clk);
        while (!dmem_req_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_valid_seen", dmem_req_valid_o, 1);
        for (int i = 0; i <= rdy_dly; i++) begin
            if (i > 0) @(negedge clk);
            check_eq("req_valid_hold", dmem_req_valid_o, 1);
            check_eq("req_addr", dmem_addr_o, e_addr);
            check_eq("req_we", dmem_we_o, e_we);
            check_eq("req_wstrb", dmem_wstrb_o, e_wstrb);
            check_eq("req_wdata", dmem_wdata_o, e_wdata);
            check_eq("ex_ready_in_req", ex_ready_o, 0);
        end
        dmem_req_ready_i = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready_i = 1'b0;
        if (!e_we) begin
            for (int i = 1; i < rsp_dly; i++) begin
                @(negedge clk);
                check_eq("ex_ready_in_resp", ex_ready_o, 0);
                @(posedge clk); #1;
            end
            dmem_rsp_rdata_i = rdata;
            dmem_rsp_valid_i = 1'b1;
            @(negedge clk);
            check_eq("ex_ready_rsp_cycle", ex_ready_o, 0);
            @(posedge clk); #1;
            dmem_rsp_valid_i = 1'b0;
        end
    endtask

    // Write-back monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin : wb_mon
        wb_exp_t e;
        if (rst_n && wb_valid_o) begin
            wb_count++;
            last_wb_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_eq("wb_unexpected", wb_valid_o, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wb_result", wb_result_o, e.res);
                if (e.chk_rd) check_eq("wb_rd", wb_rd_o, e.rd);
                check_eq("wb_reg_write", wb_reg_write_o, e.rw);
                check_eq("wb_fault", wb_fault_o, e.fault);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, wc0;
        rst_n            = 1'b0;
        ex_valid_i       = 1'b0;
        ex_alu_result_i  = 32'd0;
        ex_store_data_i  = 32'd0;
        ex_funct3_i      = 3'd0;
        ex_is_load_i     = 1'b0;
        ex_is_store_i    = 1'b0;
        ex_rd_i          = 5'd0;
        ex_reg_write_i   = 1'b0;
        dmem_req_ready_i = 1'b0;
        dmem_rsp_valid_i = 1'b0;
        dmem_rsp_rdata_i = 32'd0;

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_ex_ready", ex_ready_o, 1);
        check_eq("rst_req_valid", dmem_req_valid_o, 0);
        check_eq("rst_wb_valid", wb_valid_o, 0);
        check_eq("rst_wstrb", dmem_wstrb_o, 0);
        check_eq("rst_wb_result", wb_result_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three back-to-back ALU results
        wc0 = wb_count;
        issue(32'h0000_1234, 32'd0, 3'b000, 1'b0, 1'b0, 5'd5, 1'b1);
        t0 = acc_cyc;
        push_exp(32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b1);
        issue(32'h0000_1234, 32'd0, 3'b000, 1'b0, 1'b0, 5'd5, 1'b1);
        push_exp(32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b1);
        issue(32'h0000_1234, 32'd0, 3'b000, 1'b0, 1'b0, 5'd5, 1'b1);
        push_exp(32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b1);
        ex_valid_i = 1'b0;
        @(posedge clk); #1;
        check_eq("b2b_wb_count", wb_count - wc0, 3);
        check_eq("b2b_last_wb_cyc", last_wb_cyc - t0, 3);

        // SB to byte 3 with a two-cycle ready stall
        issue(32'h0000_1003, 32'hAABB_CCDD, 3'b000, 1'b0, 1'b1, 5'd3, 1'b1);
        ex_valid_i = 1'b0;
        t0 = acc_cyc;
        push_exp(32'd0, 5'd3, 1'b0, 1'b0, 1'b0);
        mem_txn(2, 0, 32'd0, 32'h0000_1000, 1'b1, 4'b1000, 32'hDDDD_DDDD);
        check_eq("sb_ex_ready_after", ex_ready_o, 1);
        @(posedge clk); #1;
        check_eq("sb_wb_latency", last_wb_cyc - t0, 4);

        // SH to upper half
        issue(32'h0000_1002, 32'h1122_3344, 3'b001, 1'b0, 1'b1, 5'd4, 1'b0);
        ex_valid_i = 1'b0;
        push_exp(32'd0, 5'd4, 1'b0, 1'b0, 1'b0);
        mem_txn(0, 0, 32'd0, 32'h0000_1000, 1'b1, 4'b1100, 32'h3344_3344);

        // LB with a slow response, then hold of wb fields
        issue(32'h0000_2002, 32'd0, 3'b000, 1'b1, 1'b0, 5'd7, 1'b1);
        ex_valid_i = 1'b0;
        push_exp(32'hFFFF_FF80, 5'd7, 1'b1, 1'b0, 1'b1);
        mem_txn(0, 3, 32'h0080_0000, 32'h0000_2000, 1'b0, 4'b0000, 32'd0);
        @(posedge clk); #1;
        check_eq("hold_wb_valid", wb_valid_o, 0);
        check_eq("hold_wb_result", wb_result_o, 32'hFFFF_FF80);

        // LBU same data
        issue(32'h0000_2002, 32'd0, 3'b100, 1'b1, 1'b0, 5'd8, 1'b1);
        ex_valid_i = 1'b0;
        push_exp(32'h0000_0080, 5'd8, 1'b1, 1'b0, 1'b1);
        mem_txn(0, 3, 32'h0080_0000, 32'h0000_2000, 1'b0, 4'b0000, 32'd0);

        // LH / LHU on the upper half
        issue(32'h0000_3002, 32'd0, 3'b001, 1'b1, 1'b0, 5'd10, 1'b1);
        ex_valid_i = 1'b0;
        push_exp(32'hFFFF_8001, 5'd10, 1'b1, 1'b0, 1'b1);
        mem_txn(1, 1, 32'h8001_1234, 32'h0000_3000, 1'b0, 4'b0000, 32'd0);
        issue(32'h0000_3002, 32'd0, 3'b101, 1'b1, 1'b0, 5'd11, 1'b0);
        ex_valid_i = 1'b0;
        push_exp(32'h0000_8001, 5'd11, 1'b0, 1'b0, 1'b1);
        mem_txn(0, 2, 32'h8001_1234, 32'h0000_3000, 1'b0, 4'b0000, 32'd0);

        // LW with immediate ready and response: three-cycle latency
        issue(32'h0000_3000, 32'd0, 3'b010, 1'b1, 1'b0, 5'd12, 1'b1);
        ex_valid_i = 1'b0;
        t0 = acc_cyc;
        push_exp(32'hDEAD_BEEF, 5'd12, 1'b1, 1'b0, 1'b1);
        mem_txn(0, 1, 32'hDEAD_BEEF, 32'h0000_3000, 1'b0, 4'b0000, 32'd0);
        @(posedge clk); #1;
        check_eq("lw_latency", last_wb_cyc - t0, 3);

        // Faults: misaligned LH, misaligned SW, bad load funct3, load+store
        issue(32'h0000_2001, 32'd0, 3'b001, 1'b1, 1'b0, 5'd9, 1'b1);
        ex_valid_i = 1'b0;
        push_exp(32'h0000_2001, 5'd9, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("lh_fault_no_req", dmem_req_valid_o, 0);
        @(posedge clk); #1;
        issue(32'h0000_2002, 32'h1234_5678, 3'b010, 1'b0, 1'b1, 5'd9, 1'b0);
        ex_valid_i = 1'b0;
        push_exp(32'h0000_2002, 5'd9, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("sw_fault_no_req", dmem_req_valid_o, 0);
        @(posedge clk); #1;
        issue(32'h0000_4000, 32'd0, 3'b011, 1'b1, 1'b0, 5'd1, 1'b1);
        push_exp(32'h0000_4000, 5'd1, 1'b0, 1'b1, 1'b0);
        issue(32'h0000_4004, 32'd0, 3'b010, 1'b1, 1'b1, 5'd2, 1'b1);
        ex_valid_i = 1'b0;
        push_exp(32'h0000_4004, 5'd2, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("both_fault_no_req", dmem_req_valid_o, 0);
        @(posedge clk); #1;

        // Reset while waiting for a load response, then a stray response
        wc0 = wb_count;
        issue(32'h0000_5000, 32'd0, 3'b010, 1'b1, 1'b0, 5'd6, 1'b1);
        ex_valid_i = 1'b0;
        @(negedge clk);
        check_eq("rst_test_req", dmem_req_valid_o, 1);
        dmem_req_ready_i = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready_i = 1'b0;
        @(negedge clk);
        check_eq("rst_test_in_resp", ex_ready_o, 0);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ex_ready", ex_ready_o, 1);
        check_eq("rst_mid_req_valid", dmem_req_valid_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_rsp_rdata_i = 32'hCAFE_F00D;
        dmem_rsp_valid_i = 1'b1;
        @(posedge clk); #1;
        dmem_rsp_valid_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("stray_wb_valid", wb_valid_o, 0);
            check_eq("stray_ex_ready", ex_ready_o, 1);
        end
        check_eq("stray_wb_count", wb_count - wc0, 0);

        @(posedge clk); #1;
        check_eq("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
